score_counter: RTL and testbench



---
 rtl/dino_pkg.sv | 17 +
 rtl/score_counter_if.sv | 25 ++
 rtl/bcd_digit.sv | 25 ++
 rtl/score_counter.sv | 121 ++++++++++++
 tb/tb_score_counter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/dino_pkg.sv
// Shared constants and types for the score keeping logic.
package dino_pkg;

   // Run states of the score keeper.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_OVER = 2'd2
   } score_state_e;

   localparam int          BCD_DIGITS = 4;
   localparam logic [15:0] SCORE_MAX  = 16'h9999;

   // A carry out of this digit (tens) lands on a multiple of 100.
   localparam int          MILESTONE_DIGIT = 1;

endpackage

// File: rtl/score_counter_if.sv
// Game event inputs and score outputs of the score keeper.
interface score_counter_if;

   logic        game_tick;
   logic        game_start_pulse;
   logic        game_over_pulse;
   logic [15:0] o_score;
   logic [15:0] o_hi_score;
   logic [2:0]  o_speed_level;
   logic        o_milestone;
   logic        o_running;

   // Game side: drives the events, watches the score.
   modport master (
      output game_tick, game_start_pulse, game_over_pulse,
      input  o_score, o_hi_score, o_speed_level, o_milestone, o_running
   );

   // Score keeper side.
   modport slave (
      input  game_tick, game_start_pulse, game_over_pulse,
      output o_score, o_hi_score, o_speed_level, o_milestone, o_running
   );

endinterface

// File: rtl/bcd_digit.sv
// One decimal digit of the score; increments 0..9 and carries on wrap.
module bcd_digit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       inc_en,
   output logic [3:0] digit,
   output logic       carry_out
);

   assign carry_out = inc_en && (digit == 4'd9);

   // Digit register: clear wins over increment, 9 wraps to 0.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         digit <= 4'd0;
      end else if (clear) begin
         digit <= 4'd0;
      end else if (inc_en) begin
         digit <= carry_out ? 4'd0 : digit + 4'd1;
      end
   end

endmodule

// File: rtl/score_counter.sv
// Score keeper: counts points on game ticks during a run, tracks session
// high score, speed level and 100-point milestones.
module score_counter
   import dino_pkg::*;
#(
   parameter int TICKS_PER_POINT = 2,
   parameter int MAX_SPEED       = 7
) (
   input  logic           clk,
   input  logic           rst_n,
   score_counter_if.slave bus
);

   localparam logic [1:0] ST_IDLE = S_IDLE;
   localparam logic [1:0] ST_RUN  = S_RUN;
   localparam logic [1:0] ST_OVER = S_OVER;

   localparam logic [3:0] PRESC_LAST = 4'(TICKS_PER_POINT - 1);
   localparam logic [2:0] SPEED_TOP  = 3'(MAX_SPEED);

   logic [1:0]            state;
   logic [3:0]            presc;
   logic [2:0]            speed;
   logic [15:0]           hi_score;
   logic                  milestone;
   logic [15:0]           score;
   logic [BCD_DIGITS-1:0] digit_inc;
   logic [BCD_DIGITS-1:0] digit_carry;
   logic                  top_carry_unused;

   logic running;
   logic do_over;
   logic do_start;
   logic tick_run;
   logic point;
   logic saturated;
   logic hit_milestone;

   assign running   = (state == ST_RUN);
   // Over outranks start only while running; elsewhere over is ignored.
   assign do_over   = running && bus.game_over_pulse;
   assign do_start  = bus.game_start_pulse && !do_over;
   // A tick counts only in RUN with no start or over in the same cycle.
   assign tick_run  = running && bus.game_tick && !bus.game_over_pulse && !bus.game_start_pulse;
   assign point     = tick_run && (presc == PRESC_LAST);
   assign saturated = (score == SCORE_MAX);

   // Ripple chain: each digit increments when the one below carries.
   assign digit_inc[0] = point && !saturated;
   for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk       (clk),
         .rst_n     (rst_n),
         .clear     (do_start),
         .inc_en    (digit_inc[i]),
         .digit     (score[4*i +: 4]),
         .carry_out (digit_carry[i])
      );
      if (i > 0) begin : g_link
         assign digit_inc[i] = digit_carry[i-1];
      end
   end

   // Saturation gating keeps the thousands digit from ever carrying out.
   assign top_carry_unused = digit_carry[BCD_DIGITS-1];

   assign hit_milestone = digit_carry[MILESTONE_DIGIT];

   // Run state: over from RUN ends the run, start (re)enters RUN.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else if (do_over) begin
         state <= ST_OVER;
      end else if (do_start) begin
         state <= ST_RUN;
      end
   end

   // Tick prescaler: wraps after TICKS_PER_POINT ticks, cleared on run entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc <= 4'd0;
      end else if (do_start) begin
         presc <= 4'd0;
      end else if (tick_run) begin
         presc <= (presc == PRESC_LAST) ? 4'd0 : presc + 4'd1;
      end
   end

   // Milestone pulse and speed level follow the hundreds carry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         milestone <= 1'b0;
         speed     <= 3'd0;
      end else begin
         milestone <= hit_milestone;
         if (do_start) begin
            speed <= 3'd0;
         end else if (hit_milestone && speed != SPEED_TOP) begin
            speed <= speed + 3'd1;
         end
      end
   end

   // High score: packed BCD compares like the number it encodes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi_score <= 16'h0000;
      end else if (do_over && score > hi_score) begin
         hi_score <= score;
      end
   end

   assign bus.o_score       = score;
   assign bus.o_hi_score    = hi_score;
   assign bus.o_speed_level = speed;
   assign bus.o_milestone   = milestone;
   assign bus.o_running     = running;

endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: directed scenarios plus random events, every
// cycle compared against an integer-arithmetic model of the game score.
module tb_score_counter;

   localparam int TPP  = 2;
   localparam int MAXS = 7;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   score_counter_if bus ();

   score_counter #(
      .TICKS_PER_POINT (TPP),
      .MAX_SPEED       (MAXS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: plain integers, decimal score.
   bit m_run;
   int m_score;
   int m_hi;
   int m_ticks;
   int m_speed;
   bit m_ms;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit t, input bit s, input bit o, input bit r);
      m_ms = 1'b0;
      if (!r) begin
         m_run = 1'b0; m_score = 0; m_hi = 0; m_ticks = 0; m_speed = 0;
      end else if (m_run && o) begin
         if (m_score > m_hi) m_hi = m_score;
         m_run = 1'b0;
      end else if (s) begin
         m_run = 1'b1; m_score = 0; m_ticks = 0; m_speed = 0;
      end else if (m_run && t) begin
         m_ticks++;
         if (m_ticks == TPP) begin
            m_ticks = 0;
            if (m_score < 9999) begin
               m_score++;
               if (m_score % 100 == 0) begin
                  m_ms = 1'b1;
                  if (m_speed < MAXS) m_speed++;
               end
            end
         end
      end
   endtask

   task automatic check_model();
      check("score", bus.o_score, to_bcd(m_score));
      check("hi_score", bus.o_hi_score, to_bcd(m_hi));
      check("speed", {13'd0, bus.o_speed_level}, 16'(m_speed));
      check("milestone", {15'd0, bus.o_milestone}, {15'd0, m_ms});
      check("running", {15'd0, bus.o_running}, {15'd0, m_run});
   endtask

   // One clock: drive on the falling edge, compare just after the rising edge.
   task automatic step(input bit t, input bit s, input bit o, input bit r = 1'b1);
      @(negedge clk);
      bus.game_tick        = t;
      bus.game_start_pulse = s;
      bus.game_over_pulse  = o;
      rst_n                = r;
      @(posedge clk);
      model_edge(t, s, o, r);
      #1;
      check_model();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      bus.game_tick        = 1'b0;
      bus.game_start_pulse = 1'b0;
      bus.game_over_pulse  = 1'b0;
      rst_n                = 1'b0;
      m_run = 1'b0; m_score = 0; m_hi = 0; m_ticks = 0; m_speed = 0; m_ms = 1'b0;

      // Reset state.
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("rst_score", bus.o_score, 16'h0000);
      check("rst_hi", bus.o_hi_score, 16'h0000);
      check("rst_running", {15'd0, bus.o_running}, 16'd0);

      // 20 ticks -> 10 points.
      step(1'b0, 1'b1, 1'b0);
      ticks(20);
      check("t20_score", bus.o_score, 16'h0010);
      check("t20_running", {15'd0, bus.o_running}, 16'd1);
      check("t20_speed", {13'd0, bus.o_speed_level}, 16'd0);

      // 0x0099 -> 0x0100 ripples two carries and pulses the milestone once.
      ticks(179);
      check("t199_score", bus.o_score, 16'h0099);
      step(1'b1, 1'b0, 1'b0);
      check("t200_score", bus.o_score, 16'h0100);
      check("t200_ms", {15'd0, bus.o_milestone}, 16'd1);
      check("t200_speed", {13'd0, bus.o_speed_level}, 16'd1);
      step(1'b0, 1'b0, 1'b0);
      check("ms_one_cycle", {15'd0, bus.o_milestone}, 16'd0);

      // Game over at 0x0123 records the high score and holds the display.
      ticks(46);
      step(1'b0, 1'b0, 1'b1);
      check("over_hi", bus.o_hi_score, 16'h0123);
      check("over_score", bus.o_score, 16'h0123);
      check("over_running", {15'd0, bus.o_running}, 16'd0);
      step(1'b1, 1'b0, 1'b1);
      check("over_ignored", bus.o_score, 16'h0123);

      // A lower second run leaves the high score alone.
      step(1'b0, 1'b1, 1'b0);
      ticks(100);
      step(1'b0, 1'b0, 1'b1);
      check("run2_score", bus.o_score, 16'h0050);
      check("run2_hi", bus.o_hi_score, 16'h0123);

      // One-cycle reset mid-run at 0x0305 clears everything; ticks then ignored.
      step(1'b0, 1'b1, 1'b0);
      ticks(610);
      check("pre_rst_score", bus.o_score, 16'h0305);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("mid_rst_score", bus.o_score, 16'h0000);
      check("mid_rst_hi", bus.o_hi_score, 16'h0000);
      ticks(10);
      check("idle_ticks", bus.o_score, 16'h0000);
      check("idle_running", {15'd0, bus.o_running}, 16'd0);

      // Start and over together in RUN: over wins.
      step(1'b0, 1'b1, 1'b0);
      ticks(84);
      check("pre_so_score", bus.o_score, 16'h0042);
      step(1'b0, 1'b1, 1'b1);
      check("so_running", {15'd0, bus.o_running}, 16'd0);
      check("so_hi", bus.o_hi_score, 16'h0042);

      // Tick with start clears score and prescaler.
      step(1'b1, 1'b1, 1'b0);
      check("ts_from_over", bus.o_score, 16'h0000);
      ticks(5);
      step(1'b1, 1'b1, 1'b0);
      check("ts_in_run", bus.o_score, 16'h0000);
      step(1'b1, 1'b0, 1'b0);
      check("ts_presc0", bus.o_score, 16'h0000);
      step(1'b1, 1'b0, 1'b0);
      check("ts_first_pt", bus.o_score, 16'h0001);

      // Tick with over: no increment, pre-tick score is final.
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      check("to_score", bus.o_score, 16'h0001);
      check("to_hi", bus.o_hi_score, 16'h0042);

      // Random events against the model.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) != 0));
      end

      // Climb to saturation, then keep ticking.
      step(1'b0, 1'b1, 1'b0);
      ticks(2 * 9999);
      check("sat_score", bus.o_score, 16'h9999);
      check("sat_speed", {13'd0, bus.o_speed_level}, 16'd7);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'b0);
         check("sat_hold", bus.o_score, 16'h9999);
         check("sat_no_ms", {15'd0, bus.o_milestone}, 16'd0);
      end
      step(1'b0, 1'b0, 1'b1);
      check("sat_hi", bus.o_hi_score, 16'h9999);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
